// File: rtl/frac_cen_gen.sv
// Multi-channel fractional clock-enable generator: each channel is a phase
// accumulator emitting inc/mod enables per clock, plus an optional post-divided enable.
module frac_cen_gen #(
  parameter int NCH    = 2,
  parameter int ACC_W  = 22,
  parameter int POST_W = 3
) (
  input  logic                    clk_chipset,
  input  logic                    reset,
  input  logic [NCH-1:0]          en,
  input  logic                    sync_clr,
  input  logic [NCH*ACC_W-1:0]    inc,
  input  logic [NCH*ACC_W-1:0]    mod,
  input  logic [NCH*POST_W-1:0]   post_div,
  output logic [NCH-1:0]          cen,
  output logic [NCH-1:0]          cen_post,
  output logic [NCH-1:0]          cfg_err
);

  localparam logic [POST_W-1:0] PCNT_ONE = {{(POST_W-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [ACC_W-1:0]  inc_w, mod_w;
    logic [POST_W-1:0] pd_w;
    logic [ACC_W:0]    nxt;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [POST_W-1:0] pcnt_q, pcnt_d;
    logic              cen_q, cen_d;
    logic              post_q, post_d;
    logic              err_q, err_d;

    assign inc_w = inc[i*ACC_W +: ACC_W];
    assign mod_w = mod[i*ACC_W +: ACC_W];
    assign pd_w  = post_div[i*POST_W +: POST_W];

    // Sum kept one bit wider so the compare against mod never sees a wrapped value.
    assign nxt = {1'b0, acc_q} + {1'b0, inc_w};

    always_comb begin
      acc_d  = acc_q;
      pcnt_d = pcnt_q;
      cen_d  = 1'b0;
      post_d = 1'b0;
      err_d  = err_q;
      if (sync_clr || !en[i]) begin
        acc_d  = '0;
        pcnt_d = '0;
      end else begin
        if (mod_w == '0 || inc_w >= mod_w) begin
          cen_d = 1'b1;
          acc_d = '0;
          err_d = 1'b1;
        end else if (acc_q >= mod_w) begin
          // mod was lowered below the current phase: flush it out with one pulse.
          cen_d = 1'b1;
          acc_d = '0;
        end else if (nxt >= {1'b0, mod_w}) begin
          cen_d = 1'b1;
          acc_d = nxt[ACC_W-1:0] - mod_w;
        end else begin
          acc_d = nxt[ACC_W-1:0];
        end

        if (cen_d) begin
          if (pcnt_q == pd_w) begin
            post_d = 1'b1;
            pcnt_d = '0;
          end else begin
            pcnt_d = pcnt_q + PCNT_ONE;
          end
        end
      end
    end

    always_ff @(posedge clk_chipset or posedge reset) begin
      if (reset) begin
        acc_q  <= '0;
        pcnt_q <= '0;
        cen_q  <= 1'b0;
        post_q <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        pcnt_q <= pcnt_d;
        cen_q  <= cen_d;
        post_q <= post_d;
        err_q  <= err_d;
      end
    end

    assign cen[i]      = cen_q;
    assign cen_post[i] = post_q;
    assign cfg_err[i]  = err_q;
  end

endmodule

// File: tb/tb_frac_cen_gen.sv
// Self-checking bench for frac_cen_gen: closed-form pulse-count model
// (floor(n*inc/mod) per phase) plus directed runtime/gating/reset scenarios.
module tb_frac_cen_gen;
  localparam int NCH    = 2;
  localparam int ACC_W  = 22;
  localparam int POST_W = 3;

  logic                  clk_chipset = 1'b0;
  logic                  reset;
  logic [NCH-1:0]        en;
  logic                  sync_clr;
  logic [NCH*ACC_W-1:0]  inc;
  logic [NCH*ACC_W-1:0]  mod;
  logic [NCH*POST_W-1:0] post_div;
  logic [NCH-1:0]        cen;
  logic [NCH-1:0]        cen_post;
  logic [NCH-1:0]        cfg_err;

  int errors = 0;
  int checks = 0;

  // Model: phase index n since the last clear, pulse count pc since the last clear.
  longint m_n[NCH];
  longint m_pc[NCH];
  bit     exp_cen[NCH];
  bit     exp_post[NCH];
  bit     exp_err[NCH];

  frac_cen_gen #(.NCH(NCH), .ACC_W(ACC_W), .POST_W(POST_W)) dut (
    .clk_chipset(clk_chipset),
    .reset(reset),
    .en(en),
    .sync_clr(sync_clr),
    .inc(inc),
    .mod(mod),
    .post_div(post_div),
    .cen(cen),
    .cen_post(cen_post),
    .cfg_err(cfg_err)
  );

  always #5 clk_chipset = ~clk_chipset;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_n[c] = 0; m_pc[c] = 0;
      exp_cen[c] = 0; exp_post[c] = 0; exp_err[c] = 0;
    end
  endtask

  task automatic set_ch(input int c, input longint inc_v, input longint mod_v, input int pd_v);
    inc[c*ACC_W +: ACC_W]       = ACC_W'(inc_v);
    mod[c*ACC_W +: ACC_W]       = ACC_W'(mod_v);
    post_div[c*POST_W +: POST_W] = POST_W'(pd_v);
  endtask

  // Advance one clock; inputs are sampled as they stand, outputs read 1 unit after the edge.
  task automatic tick();
    logic [NCH-1:0] en_s;
    logic           clr_s, rst_s;
    longint         inc_s[NCH], mod_s[NCH], pd_s[NCH];
    en_s = en; clr_s = sync_clr; rst_s = reset;
    for (int c = 0; c < NCH; c++) begin
      inc_s[c] = longint'(inc[c*ACC_W +: ACC_W]);
      mod_s[c] = longint'(mod[c*ACC_W +: ACC_W]);
      pd_s[c]  = longint'(post_div[c*POST_W +: POST_W]);
    end
    @(posedge clk_chipset); #1;
    if (rst_s) begin
      model_reset();
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (clr_s || !en_s[c]) begin
          m_n[c] = 0; m_pc[c] = 0; exp_cen[c] = 0; exp_post[c] = 0;
        end else if (mod_s[c] == 0 || inc_s[c] >= mod_s[c]) begin
          m_n[c] = 0; m_pc[c]++; exp_cen[c] = 1; exp_err[c] = 1;
          exp_post[c] = (m_pc[c] % (pd_s[c] + 1)) == 0;
        end else begin
          m_n[c]++;
          exp_cen[c] = ((m_n[c] * inc_s[c]) / mod_s[c] - ((m_n[c] - 1) * inc_s[c]) / mod_s[c]) != 0;
          if (exp_cen[c]) m_pc[c]++;
          exp_post[c] = exp_cen[c] && ((m_pc[c] % (pd_s[c] + 1)) == 0);
        end
      end
    end
  endtask

  task automatic hold_reset();
    reset = 1'b1; sync_clr = 1'b0;
    @(posedge clk_chipset); #1;
    model_reset();
  endtask

  task automatic release_reset();
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset = 1'b1; sync_clr = 1'b0; en = '1;
    set_ch(0, 5000, 5000, 0);
    set_ch(1, 1, 0, 0);
    repeat (3) @(posedge clk_chipset);
    #1;
    checks++; if (cen !== 2'b00) begin errors++; $display("FAIL reset_cen: got %b want 00", cen); end
    checks++; if (cen_post !== 2'b00) begin errors++; $display("FAIL reset_cen_post: got %b want 00", cen_post); end
    checks++; if (cfg_err !== 2'b00) begin errors++; $display("FAIL reset_cfg_err: got %b want 00", cfg_err); end
  endtask

  task automatic test_valid_ratio();
    int first0, last0, min_gap, max_gap, cnt0_5k, cnt1, post1, post_wo_cen, bad_per, cps, post_neq0;
    hold_reset();
    set_ch(0, 358, 5000, 0);
    set_ch(1, 14815, 50000, 7);
    en = 2'b11;
    release_reset();
    first0 = -1; last0 = -1; min_gap = 1 << 30; max_gap = 0;
    cnt0_5k = 0; cnt1 = 0; post1 = 0; post_wo_cen = 0; bad_per = 0; cps = 0; post_neq0 = 0;
    for (int k = 1; k <= 50000; k++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if ({cen[c], cen_post[c], cfg_err[c]} !== {exp_cen[c], exp_post[c], exp_err[c]}) begin
          errors++;
          $display("FAIL valid_model ch%0d tick %0d: got cen/post/err=%b%b%b want %b%b%b",
                   c, k, cen[c], cen_post[c], cfg_err[c], exp_cen[c], exp_post[c], exp_err[c]);
        end
      end
      if (cen[0]) begin
        if (first0 < 0) first0 = k;
        else begin
          if (k - last0 < min_gap) min_gap = k - last0;
          if (k - last0 > max_gap) max_gap = k - last0;
        end
        last0 = k;
        if (k <= 5000) cnt0_5k++;
      end
      if (cen_post[0] !== cen[0]) post_neq0++;
      if (cen[1]) begin cnt1++; cps++; end
      if (cen_post[1]) begin
        post1++;
        if (!cen[1]) post_wo_cen++;
        if (cps != 8) bad_per++;
        cps = 0;
      end
    end
    checks++; if (first0 != 14) begin errors++; $display("FAIL first_pulse: got tick %0d want 14", first0); end
    checks++; if (min_gap != 13 || max_gap != 14) begin errors++; $display("FAIL gap_range: got %0d..%0d want 13..14", min_gap, max_gap); end
    checks++; if (cnt0_5k != 358) begin errors++; $display("FAIL rate_ch0: got %0d want 358", cnt0_5k); end
    checks++; if (post_neq0 != 0) begin errors++; $display("FAIL post_eq_cen_ch0: got %0d diffs want 0", post_neq0); end
    checks++; if (cnt1 != 14815) begin errors++; $display("FAIL rate_ch1: got %0d want 14815", cnt1); end
    checks++; if (post1 != 1851) begin errors++; $display("FAIL post_count_ch1: got %0d want 1851", post1); end
    checks++; if (post_wo_cen != 0 || bad_per != 0) begin errors++; $display("FAIL post_period_ch1: got orphan=%0d badper=%0d want 0 0", post_wo_cen, bad_per); end
  endtask

  task automatic test_misconfig();
    hold_reset();
    set_ch(0, 5000, 5000, 1);
    set_ch(1, 7, 0, 0);
    en = 2'b11;
    release_reset();
    for (int k = 0; k < 6; k++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if ({cen[c], cen_post[c], cfg_err[c]} !== {exp_cen[c], exp_post[c], exp_err[c]}) begin
          errors++;
          $display("FAIL misconfig_model ch%0d: got %b%b%b want %b%b%b",
                   c, cen[c], cen_post[c], cfg_err[c], exp_cen[c], exp_post[c], exp_err[c]);
        end
      end
    end
    checks++; if (cen !== 2'b11 || cfg_err !== 2'b11) begin errors++; $display("FAIL misconfig_flags: got cen=%b err=%b want 11 11", cen, cfg_err); end
    set_ch(0, 358, 5000, 1);
    set_ch(1, 1, 3, 0);
    for (int k = 0; k < 30; k++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if ({cen[c], cen_post[c], cfg_err[c]} !== {exp_cen[c], exp_post[c], exp_err[c]}) begin
          errors++;
          $display("FAIL restore_model ch%0d: got %b%b%b want %b%b%b",
                   c, cen[c], cen_post[c], cfg_err[c], exp_cen[c], exp_post[c], exp_err[c]);
        end
      end
    end
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    checks++; if (cfg_err !== 2'b11) begin errors++; $display("FAIL err_sticky_sync_clr: got %b want 11", cfg_err); end
    reset = 1'b1; #1;
    checks++; if (cfg_err !== 2'b00) begin errors++; $display("FAIL err_cleared_by_reset: got %b want 00", cfg_err); end
    tick();
  endtask

  task automatic test_runtime_mod();
    logic [3:0] seq;
    hold_reset();
    set_ch(0, 40, 5000, 0);
    set_ch(1, 1, 2, 0);
    en = 2'b01;
    release_reset();
    for (int k = 0; k < 100; k++) begin
      tick();
      checks++;
      if (cen[0] !== exp_cen[0]) begin errors++; $display("FAIL pre_lower ch0: got %b want %b", cen[0], exp_cen[0]); end
    end
    set_ch(0, 40, 100, 0);
    for (int k = 3; k >= 0; k--) begin
      tick();
      seq[k] = cen[0];
    end
    checks++; if (seq !== 4'b1001) begin errors++; $display("FAIL mod_lowered_seq: got %b want 1001", seq); end
    checks++; if (cfg_err[0] !== 1'b0) begin errors++; $display("FAIL mod_lowered_err: got %b want 0", cfg_err[0]); end
    en = 2'b00; tick();
  endtask

  task automatic test_gating();
    hold_reset();
    set_ch(0, 358, 5000, 2);
    set_ch(1, 358, 5000, 2);
    en = 2'b11;
    release_reset();
    for (int k = 0; k < 40; k++) tick();
    en = 2'b10;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({cen[0], cen_post[0]} !== 2'b00 || cen[1] !== exp_cen[1]) begin
        errors++; $display("FAIL gated_ch0: got cen=%b post=%b want ch0 00 ch1 %b", cen, cen_post, exp_cen[1]);
      end
    end
    en = 2'b11;
    for (int k = 0; k < 60; k++) begin
      tick();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if ({cen[c], cen_post[c]} !== {exp_cen[c], exp_post[c]}) begin
          errors++; $display("FAIL reenable ch%0d: got %b%b want %b%b", c, cen[c], cen_post[c], exp_cen[c], exp_post[c]);
        end
      end
    end
    sync_clr = 1'b1; tick(); sync_clr = 1'b0;
    for (int k = 0; k < 200; k++) begin
      tick();
      checks++;
      if (cen[0] !== cen[1] || cen_post[0] !== cen_post[1] || cen[0] !== exp_cen[0] || cen_post[0] !== exp_post[0]) begin
        errors++; $display("FAIL aligned tick %0d: got cen=%b post=%b want both %b/%b", k, cen, cen_post, exp_cen[0], exp_post[0]);
      end
    end
    sync_clr = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick();
      checks++;
      if (cen !== 2'b00 || cen_post !== 2'b00) begin errors++; $display("FAIL sync_clr_held: got cen=%b post=%b want 00 00", cen, cen_post); end
    end
    sync_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    int waited, first0;
    hold_reset();
    set_ch(0, 358, 5000, 0);
    set_ch(1, 3, 0, 0);
    en = 2'b11;
    release_reset();
    waited = 0;
    do begin tick(); waited++; end while (cen[0] !== 1'b1 && waited < 100);
    checks++; if (cen[0] !== 1'b1) begin errors++; $display("FAIL reset_mid_wait: no cen[0] pulse in %0d cycles", waited); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cen !== 2'b00 || cen_post !== 2'b00 || cfg_err !== 2'b00) begin
      errors++; $display("FAIL reset_mid_async: got cen=%b post=%b err=%b want 00 00 00", cen, cen_post, cfg_err);
    end
    set_ch(1, 358, 5000, 0);
    @(posedge clk_chipset); #1;
    release_reset();
    first0 = -1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (cen[0] && first0 < 0) first0 = k;
      checks++;
      if (cen[1] !== exp_cen[1]) begin errors++; $display("FAIL post_reset ch1 tick %0d: got %b want %b", k, cen[1], exp_cen[1]); end
    end
    checks++; if (first0 != 14) begin errors++; $display("FAIL post_reset_first: got tick %0d want 14", first0); end
  endtask

  task automatic test_random();
    longint mv, iv;
    hold_reset();
    en = 2'b11;
    release_reset();
    for (int seg = 0; seg < 8; seg++) begin
      for (int c = 0; c < NCH; c++) begin
        mv = longint'($urandom_range(4000, 2));
        if ($urandom_range(3, 0) == 0) iv = mv - 1;
        else iv = longint'($urandom_range(32'(mv - 1), 0));
        set_ch(c, iv, mv, int'($urandom_range(7, 0)));
      end
      sync_clr = 1'b1; tick(); sync_clr = 1'b0;
      for (int k = 0; k < 600; k++) begin
        if ($urandom_range(39, 0) == 0) en[$urandom_range(1, 0)] ^= 1'b1;
        if ($urandom_range(199, 0) == 0) sync_clr = 1'b1;
        tick();
        sync_clr = 1'b0;
        for (int c = 0; c < NCH; c++) begin
          checks++;
          if ({cen[c], cen_post[c], cfg_err[c]} !== {exp_cen[c], exp_post[c], exp_err[c]}) begin
            errors++;
            $display("FAIL random seg %0d ch%0d tick %0d: got %b%b%b want %b%b%b",
                     seg, c, k, cen[c], cen_post[c], cfg_err[c], exp_cen[c], exp_post[c], exp_err[c]);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1; en = '0; sync_clr = 1'b0; inc = '0; mod = '0; post_div = '0;
    model_reset();
    test_reset();
    test_valid_ratio();
    test_misconfig();
    test_runtime_mod();
    test_gating();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
